// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: fixed priority to
// req0 with starvation relief for req1, plus a pending-write scoreboard for decode.
module regfile_wb_arbiter #(
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [4:0]  req0_rd,
   input  logic [31:0] req0_data,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [4:0]  req1_rd,
   input  logic [31:0] req1_data,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   output logic        wr_en,
   output logic [4:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic [31:0] pending
);

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   // Handshake: a transfer happens when valid & ready in the same cycle; a
   // requester holds valid, rd and data stable until it sees ready.
   logic [CW-1:0] starve_cnt_q, starve_cnt_d;
   logic          wr_en_q, wr_en_d;
   logic [4:0]    wr_addr_q, wr_addr_d;
   logic [31:0]   wr_data_q, wr_data_d;
   logic [31:0]   pending_q, pending_d;
   logic          force1;
   logic          xfer;
   logic [4:0]    win_rd;
   logic [31:0]   win_data;

   always_comb begin
      force1     = (starve_cnt_q == CW'(STARVE_LIMIT));
      req1_ready = req1_valid & (~req0_valid | force1);
      req0_ready = req0_valid & ~req1_ready;
      xfer       = req0_ready | req1_ready;
      win_rd     = req1_ready ? req1_rd : req0_rd;
      win_data   = req1_ready ? req1_data : req0_data;
   end

   always_comb begin
      starve_cnt_d = '0;
      if (req1_valid & ~req1_ready) begin
         starve_cnt_d = force1 ? starve_cnt_q : starve_cnt_q + CW'(1);
      end

      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (xfer) begin
         wr_en_d   = (win_rd != 5'd0);
         wr_addr_d = win_rd;
         wr_data_d = win_data;
      end

      // Set is applied after clear so a newer producer stays outstanding.
      pending_d = pending_q;
      if (xfer && win_rd != 5'd0) begin
         pending_d[win_rd] = 1'b0;
      end
      if (issue_valid && issue_rd != 5'd0) begin
         pending_d[issue_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= 5'd0;
         wr_data_q    <= 32'd0;
         pending_q    <= 32'd0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         pending_q    <= pending_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_regfile_wb_arbiter;

   localparam int LIMIT = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0;
   logic        req0_ready;
   logic [4:0]  req0_rd = 5'd0;
   logic [31:0] req0_data = 32'd0;
   logic        req1_valid = 1'b0;
   logic        req1_ready;
   logic [4:0]  req1_rd = 5'd0;
   logic [31:0] req1_data = 32'd0;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = 5'd0;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] pending;

   int n_checks = 0;
   int n_errors = 0;

   regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_rd     (req0_rd),
      .req0_data   (req0_data),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_rd     (req1_rd),
      .req1_data   (req1_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .pending     (pending)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: expected write-port contents per cycle as {en, addr, data}
   logic [37:0] exp_q[$];
   logic [31:0] m_pend;
   int          m_refused;
   logic [4:0]  m_last_addr;
   logic [31:0] m_last_data;

   always @(negedge clk) begin
      logic [37:0] e;
      logic        r0, r1;
      logic [4:0]  rd;
      logic [31:0] dat;
      if (!rst_n) begin
         exp_q = {};
         exp_q.push_back(38'd0);
         m_pend = 32'd0;
         m_refused = 0;
         m_last_addr = 5'd0;
         m_last_data = 32'd0;
      end else begin
         e = exp_q.pop_front();
         check("m_wr_en", 64'(wr_en), 64'(e[37]));
         check("m_wr_addr", 64'(wr_addr), 64'(e[36:32]));
         check("m_wr_data", 64'(wr_data), 64'(e[31:0]));
         check("m_pending", 64'(pending), 64'(m_pend));
         // req1 wins when req0 is silent or req1 has been refused LIMIT times in a row
         r1 = req1_valid && (!req0_valid || m_refused >= LIMIT);
         r0 = req0_valid && !r1;
         check("m_req0_ready", 64'(req0_ready), 64'(r0));
         check("m_req1_ready", 64'(req1_ready), 64'(r1));
         rd  = r1 ? req1_rd : req0_rd;
         dat = r1 ? req1_data : req0_data;
         if (r0 || r1) begin
            m_last_addr = rd;
            m_last_data = dat;
            exp_q.push_back({rd != 5'd0, rd, dat});
            if (rd != 5'd0) m_pend[rd] = 1'b0;
         end else begin
            exp_q.push_back({1'b0, m_last_addr, m_last_data});
         end
         if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
         if (req1_valid && !r1) m_refused = (m_refused < LIMIT) ? m_refused + 1 : LIMIT;
         else m_refused = 0;
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      issue_valid = 1'b0;
   endtask

   task automatic set_req0(input logic [4:0] rd, input logic [31:0] d);
      req0_valid = 1'b1;
      req0_rd = rd;
      req0_data = d;
   endtask

   task automatic set_req1(input logic [4:0] rd, input logic [31:0] d);
      req1_valid = 1'b1;
      req1_rd = rd;
      req1_data = d;
   endtask

   task automatic random_phase(input int cycles, input int p0, input int p1);
      bit d0, d1;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         d0 = req0_valid && req0_ready;
         d1 = req1_valid && req1_ready;
         tick();
         if (!req0_valid || d0) begin
            req0_valid = ($urandom_range(0, 99) < p0);
            req0_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            req0_data  = $urandom;
         end
         if (!req1_valid || d1) begin
            req1_valid = ($urandom_range(0, 99) < p1);
            req1_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            req1_data  = $urandom;
         end
         issue_valid = ($urandom_range(0, 99) < 35);
         issue_rd    = 5'($urandom_range(0, 31));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset
      tick();
      tick();
      check("rst_wr_en", 64'(wr_en), 64'd0);
      check("rst_pending", 64'(pending), 64'd0);
      rst_n = 1'b1;
      tick();
      tick();
      check("idle_wr_en", 64'(wr_en), 64'd0);
      check("idle_pending", 64'(pending), 64'd0);

      // Single req0 write
      set_req0(5'd5, 32'hDEADBEEF);
      #1 check("t2_ready", 64'(req0_ready), 64'd1);
      tick();
      idle();
      #1 check("t2_wr_en", 64'(wr_en), 64'd1);
      check("t2_wr_addr", 64'(wr_addr), 64'd5);
      check("t2_wr_data", 64'(wr_data), 64'hDEADBEEF);
      tick();
      #1 check("t2_wr_en_off", 64'(wr_en), 64'd0);

      // Contention: req0 wins LIMIT cycles, then req1 is forced through
      tick();
      set_req0(5'd1, 32'h11);
      set_req1(5'd2, 32'h22);
      for (int i = 0; i < LIMIT; i++) begin
         #1 check("t3_req0_wins", 64'({req0_ready, req1_ready}), 64'b10);
         tick();
      end
      #1 check("t3_req1_forced", 64'({req0_ready, req1_ready}), 64'b01);
      tick();
      set_req1(5'd4, 32'h44);
      #1 check("t3_cnt_cleared", 64'({req0_ready, req1_ready}), 64'b10);
      tick();
      idle();
      tick();
      tick();

      // x0 write accepted but suppressed
      set_req1(5'd0, 32'h1234);
      #1 check("t4_ready", 64'(req1_ready), 64'd1);
      tick();
      idle();
      #1 check("t4_wr_en", 64'(wr_en), 64'd0);
      check("t4_pending", 64'(pending), 64'd0);

      // Scoreboard set / clear / same-edge
      tick();
      issue_valid = 1'b1;
      issue_rd = 5'd7;
      tick();
      issue_valid = 1'b0;
      #1 check("t5_pend7_set", 64'(pending[7]), 64'd1);
      tick();
      tick();
      set_req1(5'd7, 32'h77);
      #1 check("t5_pend7_hold", 64'(pending[7]), 64'd1);
      tick();
      idle();
      #1 check("t5_pend7_clr", 64'(pending[7]), 64'd0);
      tick();
      set_req0(5'd9, 32'h99);
      issue_valid = 1'b1;
      issue_rd = 5'd9;
      tick();
      idle();
      #1 check("t5_pend9_set_wins", 64'(pending[9]), 64'd1);
      check("t5_wr_addr9", 64'(wr_addr), 64'd9);

      // Reset the cycle after a transfer
      tick();
      set_req0(5'd3, 32'hCAFE);
      issue_valid = 1'b1;
      issue_rd = 5'd12;
      tick();
      idle();
      #1 check("t6_wr_en_pre", 64'(wr_en), 64'd1);
      check("t6_pend12_pre", 64'(pending[12]), 64'd1);
      rst_n = 1'b0;
      #1 check("t6_wr_en_async", 64'(wr_en), 64'd0);
      check("t6_pending_async", 64'(pending), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      #1 check("t6_wr_en_after", 64'(wr_en), 64'd0);
      check("t6_pending_after", 64'(pending), 64'd0);

      // Randomized traffic at varying req0 pressure
      random_phase(800, 60, 50);
      random_phase(800, 95, 70);
      random_phase(400, 30, 30);
      tick();
      idle();
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
